// File: rtl/key_sched_pkg.sv
// Shared definitions for the key event scheduler.
// Holds the event type codes, the per-key debounce FSM state encoding and
// small width helper functions used to size ports and counters.
package key_sched_pkg;

    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_RELEASE = 2'd1;
    localparam logic [1:0] EV_REPEAT  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESS_DEB   = 2'd1,
        ST_HELD        = 2'd2,
        ST_RELEASE_DEB = 2'd3
    } key_state_t;

    // ceil(log2(v)); 0 for v <= 1
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // width of a key index, never narrower than one bit
    function automatic int key_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/key_event_scheduler_if.sv
// Event port of the key event scheduler: one valid/ready channel carrying
// the index of the key that raised the event and the event type.
//   ev_valid : event available (driven by the scheduler)
//   ev_ready : consumer accepts the event
//   ev_key   : key index
//   ev_type  : EV_PRESS / EV_RELEASE / EV_REPEAT
interface key_event_scheduler_if import key_sched_pkg::*; #(
    parameter int N_KEYS = 4
);
    localparam int KW = key_w(N_KEYS);

    logic          ev_valid;
    logic          ev_ready;
    logic [KW-1:0] ev_key;
    logic [1:0]    ev_type;

    modport master (output ev_valid, output ev_key, output ev_type, input ev_ready);
    modport slave  (input ev_valid, input ev_key, input ev_type, output ev_ready);

endinterface

// File: rtl/key_channel.sv
// One key of the scheduler: two-flop synchroniser, debounce/repeat FSM and
// a single-entry pending event slot.
//   clk, rst  : system clock, synchronous active-high reset
//   tick      : shared sample tick; the FSM only advances on tick cycles
//   raw       : asynchronous button input, 1 = pressed
//   grant     : the arbiter takes the pending slot on this edge
//   level     : debounced key level
//   pend_vld  : pending slot holds an event
//   pend_type : type of the pending event
//   ovf       : a PRESS/RELEASE is overwriting an unserved event this cycle
module key_channel import key_sched_pkg::*; #(
    parameter int DEB_TICKS    = 4,
    parameter int HOLD_TICKS   = 64,
    parameter int REPEAT_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       raw,
    input  logic       grant,
    output logic       level,
    output logic       pend_vld,
    output logic [1:0] pend_type,
    output logic       ovf
);
    localparam int DW   = clog2(DEB_TICKS + 1);
    localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int HW   = clog2(HMAX + 1);
    localparam logic [DW-1:0] DEB_LIM  = DW'(DEB_TICKS);
    localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] REP_LIM  = HW'(REPEAT_TICKS);

    logic          s_meta, s;
    key_state_t    state, state_nx;
    logic [DW-1:0] deb_cnt, deb_nx, deb_inc;
    logic [HW-1:0] hold_cnt, hold_nx, hold_inc, hold_lim;
    logic          rep_mode, rep_nx;
    logic          level_nx;
    logic          post;
    logic [1:0]    post_type;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_meta   <= 1'b0;
            s        <= 1'b0;
            state    <= ST_IDLE;
            deb_cnt  <= '0;
            hold_cnt <= '0;
            rep_mode <= 1'b0;
            level    <= 1'b0;
        end else begin
            s_meta   <= raw;
            s        <= s_meta;
            state    <= state_nx;
            deb_cnt  <= deb_nx;
            hold_cnt <= hold_nx;
            rep_mode <= rep_nx;
            level    <= level_nx;
        end
    end

    // hold_cnt counts towards HOLD_TICKS for the first repeat and towards
    // REPEAT_TICKS afterwards (rep_mode); this is the same cadence as
    // reloading HOLD_TICKS-REPEAT_TICKS but stays valid when REPEAT > HOLD.
    always_comb begin
        state_nx  = state;
        deb_nx    = deb_cnt;
        hold_nx   = hold_cnt;
        rep_nx    = rep_mode;
        level_nx  = level;
        post      = 1'b0;
        post_type = EV_PRESS;
        deb_inc   = deb_cnt + DW'(1);
        hold_inc  = hold_cnt + HW'(1);
        hold_lim  = rep_mode ? REP_LIM : HOLD_LIM;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (s) begin
                        if (DEB_TICKS == 1) begin
                            state_nx = ST_HELD;
                            level_nx = 1'b1;
                            hold_nx  = '0;
                            rep_nx   = 1'b0;
                            deb_nx   = '0;
                            post     = 1'b1;
                        end else begin
                            deb_nx   = DW'(1);
                            state_nx = ST_PRESS_DEB;
                        end
                    end
                end
                ST_PRESS_DEB: begin
                    if (!s) begin
                        state_nx = ST_IDLE;
                        deb_nx   = '0;
                    end else if (deb_inc == DEB_LIM) begin
                        state_nx = ST_HELD;
                        level_nx = 1'b1;
                        hold_nx  = '0;
                        rep_nx   = 1'b0;
                        deb_nx   = '0;
                        post     = 1'b1;
                    end else begin
                        deb_nx = deb_inc;
                    end
                end
                ST_HELD: begin
                    if (s) begin
                        if (hold_inc == hold_lim) begin
                            hold_nx   = '0;
                            rep_nx    = 1'b1;
                            post      = 1'b1;
                            post_type = EV_REPEAT;
                        end else begin
                            hold_nx = hold_inc;
                        end
                    end else if (DEB_TICKS == 1) begin
                        state_nx  = ST_IDLE;
                        level_nx  = 1'b0;
                        deb_nx    = '0;
                        post      = 1'b1;
                        post_type = EV_RELEASE;
                    end else begin
                        deb_nx   = DW'(1);
                        state_nx = ST_RELEASE_DEB;
                    end
                end
                ST_RELEASE_DEB: begin
                    if (s) begin
                        state_nx = ST_HELD;
                        deb_nx   = '0;
                    end else if (deb_inc == DEB_LIM) begin
                        state_nx  = ST_IDLE;
                        level_nx  = 1'b0;
                        deb_nx    = '0;
                        post      = 1'b1;
                        post_type = EV_RELEASE;
                    end else begin
                        deb_nx = deb_inc;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // A slot granted on this edge counts as empty, so a same-edge post is kept.
    assign ovf = post && pend_vld && !grant && (post_type != EV_REPEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld  <= 1'b0;
            pend_type <= EV_PRESS;
        end else if (post) begin
            if (!pend_vld || grant) begin
                pend_vld  <= 1'b1;
                pend_type <= post_type;
            end else if (post_type != EV_REPEAT) begin
                pend_type <= post_type;
            end
        end else if (grant) begin
            pend_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/key_event_scheduler.sv
// Multi-button front end: shared sample tick, one debounce channel per key
// and a round-robin arbiter serialising PRESS/RELEASE/REPEAT events onto a
// single valid/ready port.
//   clk, rst  : system clock, synchronous active-high reset
//   key_raw   : asynchronous buttons, 1 = pressed
//   key_level : debounced level per key
//   ev        : event port (master side of key_event_scheduler_if)
//   overflow  : sticky; a PRESS/RELEASE overwrote an unserved event
module key_event_scheduler import key_sched_pkg::*; #(
    parameter int N_KEYS       = 4,
    parameter int TICK_DIV     = 16,
    parameter int DEB_TICKS    = 4,
    parameter int HOLD_TICKS   = 64,
    parameter int REPEAT_TICKS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_KEYS-1:0]     key_raw,
    output logic [N_KEYS-1:0]     key_level,
    key_event_scheduler_if.master ev,
    output logic                  overflow
);
    localparam int KW = key_w(N_KEYS);
    localparam int TW = clog2(TICK_DIV);

    logic [TW-1:0]     tick_cnt;
    logic              tick;
    logic [N_KEYS-1:0] pend_vld, ovf_vec, grant_vec;
    logic [1:0]        pend_type [N_KEYS];
    logic [KW-1:0]     rr_ptr, grant_idx, rr_nx;
    logic              grant_any, load;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_channel #(
            .DEB_TICKS   (DEB_TICKS),
            .HOLD_TICKS  (HOLD_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .raw      (key_raw[i]),
            .grant    (grant_vec[i]),
            .level    (key_level[i]),
            .pend_vld (pend_vld[i]),
            .pend_type(pend_type[i]),
            .ovf      (ovf_vec[i])
        );
    end

    // Round-robin search: first pending key at or after rr_ptr.
    always_comb begin
        grant_vec = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        load      = !ev.ev_valid || ev.ev_ready;
        if (load) begin
            for (int k = 0; k < N_KEYS; k++) begin
                if (!grant_any && pend_vld[(int'(rr_ptr) + k) % N_KEYS]) begin
                    grant_any = 1'b1;
                    grant_idx = KW'((int'(rr_ptr) + k) % N_KEYS);
                end
            end
        end
        if (grant_any) grant_vec[grant_idx] = 1'b1;
        rr_nx = (grant_idx == KW'(N_KEYS - 1)) ? '0 : grant_idx + KW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ev.ev_valid <= 1'b0;
            ev.ev_key   <= '0;
            ev.ev_type  <= EV_PRESS;
            rr_ptr      <= '0;
            overflow    <= 1'b0;
        end else begin
            if (grant_any) begin
                ev.ev_valid <= 1'b1;
                ev.ev_key   <= grant_idx;
                ev.ev_type  <= pend_type[grant_idx];
                rr_ptr      <= rr_nx;
            end else if (load) begin
                ev.ev_valid <= 1'b0;
            end
            overflow <= overflow | (|ovf_vec);
        end
    end

endmodule

// File: tb/tb_key_event_scheduler.sv
module tb_key_event_scheduler;
    import key_sched_pkg::*;

    typedef struct {
        int key;
        int typ;
        int gap;   // required cycles since previous event; 0 = not checked
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] key_raw;
    logic [3:0] key_level;
    logic       overflow;

    key_event_scheduler_if #(.N_KEYS(4)) bus ();

    key_event_scheduler #(
        .N_KEYS      (4),
        .TICK_DIV    (4),
        .DEB_TICKS   (3),
        .HOLD_TICKS  (8),
        .REPEAT_TICKS(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_raw  (key_raw),
        .key_level(key_level),
        .ev       (bus),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_pop = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int key, input int typ, input int gap);
        exp_t e;
        e.key = key;
        e.typ = typ;
        e.gap = gap;
        sb.push_back(e);
    endtask

    // One clock: watch the event port at the falling edge, then step past
    // the rising edge so the caller can drive new inputs.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (bus.ev_valid === 1'b1 && bus.ev_ready === 1'b1) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_event: observed key=%0d type=%0d, expected no event",
                       bus.ev_key, bus.ev_type);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("ev_key", 32'(bus.ev_key), 32'(e.key));
                check("ev_type", 32'(bus.ev_type), 32'(e.typ));
                if (e.gap != 0) check("ev_gap", 32'(cyc - last_pop), 32'(e.gap));
            end
            last_pop = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_level(input int idx, input logic val, input int max, output int n);
        n = 0;
        while (key_level[idx] !== val && n < max) begin
            cycle();
            n++;
        end
        if (key_level[idx] !== val) n = -1;
    endtask

    task automatic wait_empty(input string tag, input int max);
        int i;
        i = 0;
        while (sb.size() != 0 && i < max) begin
            cycle();
            i++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"}, 32'(key_level), 32'd0);
        check({tag, "_valid"}, 32'(bus.ev_valid), 32'd0);
        check({tag, "_key"}, 32'(bus.ev_key), 32'd0);
        check({tag, "_type"}, 32'(bus.ev_type), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        int n;
        logic ok;
        logic seen;

        rst = 1'b1;
        key_raw = 4'b0000;
        bus.ev_ready = 1'b1;
        repeat (3) cycle();
        check_all_zero("reset");
        rst = 1'b0;

        // clean press of key 1, 40 cycles
        push(1, EV_PRESS, 0);
        key_raw[1] = 1'b1;
        wait_level(1, 1'b1, 30, n);
        check("t1_rise_latency", 32'(n >= 11 && n <= 14), 32'd1);
        check("t1_valid_lags_level", 32'(bus.ev_valid), 32'd0);
        cycle();
        repeat (40 - n - 1) cycle();
        check("t1_level_held", 32'(key_level[1]), 32'd1);
        push(1, EV_RELEASE, 0);
        key_raw[1] = 1'b0;
        wait_level(1, 1'b0, 30, n);
        check("t1_fall_latency", 32'(n >= 11 && n <= 14), 32'd1);
        wait_empty("t1_drain", 10);

        // key 0 bounces once per tick, then settles low
        seen = 1'b0;
        for (int b = 0; b < 4; b++) begin
            key_raw[0] = ~b[0];
            for (int c = 0; c < 4; c++) begin
                cycle();
                seen = seen | key_level[0];
            end
        end
        key_raw[0] = 1'b0;
        for (int c = 0; c < 30; c++) begin
            cycle();
            seen = seen | key_level[0];
        end
        check("t2_bounce_level", 32'(seen), 32'd0);

        // key 2 held for 20 ticks: PRESS, REPEAT at hold ticks 8/12/16
        push(2, EV_PRESS, 0);
        push(2, EV_REPEAT, 32);
        push(2, EV_REPEAT, 16);
        push(2, EV_REPEAT, 16);
        push(2, EV_RELEASE, 0);
        key_raw[2] = 1'b1;
        repeat (80) cycle();
        key_raw[2] = 1'b0;
        wait_empty("t3_drain", 60);
        check("t3_level_low", 32'(key_level[2]), 32'd0);

        // keys 0 and 3 together, round-robin from a fresh pointer
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        push(0, EV_PRESS, 0);
        push(3, EV_PRESS, 1);
        key_raw = 4'b1001;
        wait_empty("t4_press_pair", 30);
        check("t4_levels", 32'(key_level), 32'b1001);
        push(0, EV_RELEASE, 0);
        push(3, EV_RELEASE, 1);
        key_raw = 4'b0000;
        wait_empty("t4_release_pair", 30);

        // consumer stalled: output holds, slot overwritten, overflow sticky
        bus.ev_ready = 1'b0;
        push(1, EV_PRESS, 0);
        push(1, EV_PRESS, 1);
        key_raw[1] = 1'b1;
        wait_level(1, 1'b1, 30, n);
        check("t5_rise_latency", 32'(n >= 11 && n <= 14), 32'd1);
        ok = 1'b1;
        for (int c = 0; c < 16; c++) begin
            cycle();
            ok = ok & (bus.ev_valid === 1'b1) & (bus.ev_key === 2'd1) & (bus.ev_type === EV_PRESS);
        end
        check("t5_stall_stable", 32'(ok), 32'd1);
        key_raw[1] = 1'b0;
        wait_level(1, 1'b0, 30, n);
        check("t5_fall_latency", 32'(n >= 11 && n <= 14), 32'd1);
        check("t5_hold_type", 32'(bus.ev_type), 32'(EV_PRESS));
        check("t5_no_overflow_yet", 32'(overflow), 32'd0);
        key_raw[1] = 1'b1;
        wait_level(1, 1'b1, 30, n);
        check("t5_overflow_set", 32'(overflow), 32'd1);
        check("t5_still_holding", 32'(bus.ev_valid), 32'd1);
        bus.ev_ready = 1'b1;
        wait_empty("t5_drain", 10);
        push(1, EV_RELEASE, 0);
        key_raw[1] = 1'b0;
        wait_empty("t5_release", 30);
        check("t5_overflow_sticky", 32'(overflow), 32'd1);

        // reset while key 2 held and an event waits
        bus.ev_ready = 1'b0;
        push(2, EV_PRESS, 0);
        key_raw[2] = 1'b1;
        wait_level(2, 1'b1, 30, n);
        cycle();
        check("t6_valid_before_rst", 32'(bus.ev_valid), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sb.delete();
        check_all_zero("t6_after_rst");
        bus.ev_ready = 1'b1;
        push(2, EV_PRESS, 0);
        wait_level(2, 1'b1, 30, n);
        check("t6_fresh_latency", 32'(n), 32'd12);
        wait_empty("t6_press", 10);
        push(2, EV_RELEASE, 0);
        key_raw[2] = 1'b0;
        wait_empty("t6_release", 30);
        repeat (10) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
